// File: rtl/ysyx_24100005_rf_wb_pkg.sv
// Shared constants for the register-file write-back path.
// Widths, the x0 address and write-back requester indices.
package ysyx_24100005_rf_wb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int REG_X0    = 0;

  localparam int WB_EXU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_NR  = 2;

endpackage

// File: rtl/ysyx_24100005_Reg.sv
// Generic register with load enable.
// Synchronous active-low reset to RESET_VAL.
module ysyx_24100005_Reg #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wen,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/ysyx_24100005_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr upward.
// ptr moves past the granted requester on every grant.
module ysyx_24100005_rr_arbiter #(
  parameter int NR_REQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NR_REQ-1:0] req_valid,
  output logic [NR_REQ-1:0] grant
);

  localparam int PTR_W = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NR_REQ - 1);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] cand;
  logic             found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NR_REQ; k++) begin
      cand = (int'(ptr) + k >= NR_REQ)
           ? PTR_W'(int'(ptr) + k - NR_REQ)
           : PTR_W'(int'(ptr) + k);
      if (!found && rst && req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gidx        = cand;
      end
    end
  end

  assign ptr_nxt = (gidx == LAST) ? '0 : gidx + PTR_W'(1);

  ysyx_24100005_Reg #(.WIDTH(PTR_W)) u_ptr (
    .clk  (clk),
    .rst  (rst),
    .din  (ptr_nxt),
    .wen  (found),
    .dout (ptr)
  );

endmodule

// File: rtl/ysyx_24100005_rf_wb_arbiter.sv
// Write-back controller: arbitrates the single RF write port
// and keeps the busy scoreboard used for decode stalls.
module ysyx_24100005_rf_wb_arbiter
  import ysyx_24100005_rf_wb_pkg::*;
#(
  parameter int NR_REQ     = WB_NR,
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NR_REQ-1:0]            req_valid,
  output logic [NR_REQ-1:0]            req_ready,
  input  logic [NR_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NR_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                         issue_valid,
  input  logic [ADDR_WIDTH-1:0]        issue_addr,
  output logic                         issue_ready,
  output logic [2**ADDR_WIDTH-1:0]     busy,
  output logic                         rf_wen,
  output logic [ADDR_WIDTH-1:0]        rf_waddr,
  output logic [DATA_WIDTH-1:0]        rf_wdata
);

  localparam int NR_REG = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(REG_X0);

  logic                  xfer;
  logic                  wen_nxt;
  logic                  issue_fire;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NR_REG-1:0]     busy_nxt;

  ysyx_24100005_rr_arbiter #(.NR_REQ(NR_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .grant     (req_ready)
  );

  assign xfer = |req_ready;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // x0 writes are accepted but never reach the register file
  assign wen_nxt = xfer && (sel_addr != X0);

  ysyx_24100005_Reg #(.WIDTH(1)) u_wen (
    .clk  (clk),
    .rst  (rst),
    .din  (wen_nxt),
    .wen  (1'b1),
    .dout (rf_wen)
  );

  ysyx_24100005_Reg #(.WIDTH(ADDR_WIDTH)) u_waddr (
    .clk  (clk),
    .rst  (rst),
    .din  (sel_addr),
    .wen  (xfer),
    .dout (rf_waddr)
  );

  ysyx_24100005_Reg #(.WIDTH(DATA_WIDTH)) u_wdata (
    .clk  (clk),
    .rst  (rst),
    .din  (sel_data),
    .wen  (xfer),
    .dout (rf_wdata)
  );

  assign issue_ready = (issue_addr == X0) || !busy[issue_addr];
  assign issue_fire  = issue_valid && issue_ready
                    && (issue_addr != X0);

  // set applied after clear so a same-address collision keeps the bit
  always_comb begin
    busy_nxt = busy;
    if (rf_wen) begin
      busy_nxt[rf_waddr] = 1'b0;
    end
    if (issue_fire) begin
      busy_nxt[issue_addr] = 1'b1;
    end
    busy_nxt[X0] = 1'b0;
  end

  ysyx_24100005_Reg #(.WIDTH(NR_REG)) u_busy (
    .clk  (clk),
    .rst  (rst),
    .din  (busy_nxt),
    .wen  (1'b1),
    .dout (busy)
  );

endmodule
